// File: rtl/snake_pkg.sv
// Shared types for the snake input front-end: direction encoding and the reversal helper.
package snake_pkg;

   typedef enum logic [1:0] {
      DIR_UP    = 2'd0,
      DIR_DOWN  = 2'd1,
      DIR_LEFT  = 2'd2,
      DIR_RIGHT = 2'd3
   } dir_t;

   // UP<->DOWN and LEFT<->RIGHT differ only in bit 0.
   function automatic dir_t opposite(input dir_t d);
      return dir_t'(d ^ 2'b01);
   endfunction

endpackage

// File: rtl/snake_input_ctrl_btn_debounce.sv
// One button: synchroniser chain, then (with SNAKE_INPUT_DEBOUNCE_EN) a stable-count debouncer.
// Without SNAKE_INPUT_DEBOUNCE_EN the level is the synchroniser output itself.
module btn_debounce
   import snake_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync_out;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) sync_q <= '0;
      else     sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
   end

   assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef SNAKE_INPUT_DEBOUNCE_EN
   localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [CW-1:0] cnt;
   logic          level_r;

   // The counter tracks consecutive synced cycles that disagree with the level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt     <= '0;
         level_r <= 1'b0;
      end else if (sync_out == level_r) begin
         cnt <= '0;
      end else if (cnt == CNT_LAST) begin
         cnt     <= '0;
         level_r <= ~level_r;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   assign level = level_r;
`else
   assign level = sync_out;
`endif

endmodule

// File: rtl/snake_input_ctrl.sv
// Snake game input front-end: per-button conditioning, press edges, and a filtered direction FIFO.
// Debouncing is enabled by defining SNAKE_INPUT_DEBOUNCE_EN.
module snake_input_ctrl
   import snake_pkg::*;
#(
   parameter int N_BTN           = 6,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int QUEUE_DEPTH     = 4,
   parameter int INIT_DIR        = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_BTN-1:0] i_btn,
   input  logic             i_flush,
   input  logic             i_dir_ready,
   output logic [N_BTN-1:0] o_btn_level,
   output logic [N_BTN-1:0] o_btn_press,
   output logic             o_dir_valid,
   output logic [1:0]       o_dir,
   output logic             o_queue_full,
   output logic             o_overflow
);

   localparam int              PW           = $clog2(QUEUE_DEPTH);
   localparam int              CNTW         = PW + 1;
   localparam logic [CNTW-1:0] DEPTH_C      = CNTW'(QUEUE_DEPTH);
   localparam dir_t            INIT_HEADING = dir_t'(INIT_DIR[1:0]);

   logic [N_BTN-1:0] level;
   logic [N_BTN-1:0] level_q;

   for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
      btn_debounce #(
         .SYNC_STAGES    (SYNC_STAGES),
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
         .clk  (clk),
         .rst  (rst),
         .raw  (i_btn[gi]),
         .level(level[gi])
      );
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) level_q <= '0;
      else     level_q <= level;
   end

   assign o_btn_level = level;
   assign o_btn_press = level & ~level_q;

   dir_t            cand;
   logic            cand_valid;
   logic            accept;
   logic            full;
   logic            do_pop;
   logic            do_push;
   dir_t            ref_dir;
   dir_t            mem [QUEUE_DEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic [CNTW-1:0] count;

   // Scan from RIGHT down to UP so the lowest-indexed press wins.
   always_comb begin
      cand_valid = 1'b0;
      cand       = DIR_UP;
      for (int k = 3; k >= 0; k--) begin
         if (o_btn_press[k]) begin
            cand_valid = 1'b1;
            cand       = dir_t'(k[1:0]);
         end
      end
   end

   // Handshake: an entry transfers on a cycle where o_dir_valid && i_dir_ready;
   // o_dir is stable while o_dir_valid is high and i_dir_ready is low.
   assign accept     = cand_valid && (cand != ref_dir) && (cand != opposite(ref_dir));
   assign full       = (count == DEPTH_C);
   assign do_pop     = i_dir_ready && o_dir_valid;
   assign do_push    = accept && (!full || do_pop);
   assign o_overflow = accept && full && !do_pop && !i_flush;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         ref_dir <= INIT_HEADING;
      end else if (i_flush) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         ref_dir <= INIT_HEADING;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         // A dropped press still moves the reference: it was a legal turn.
         if (accept)  ref_dir <= cand;
         if (do_push && !do_pop)      count <= count + 1'b1;
         else if (!do_push && do_pop) count <= count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !i_flush) mem[wr_ptr] <= cand;
   end

   assign o_dir_valid  = (count != '0);
   assign o_dir        = o_dir_valid ? mem[rd_ptr] : DIR_UP;
   assign o_queue_full = full;

endmodule

// File: tb/tb_snake_input_ctrl.sv
// Bench for snake_input_ctrl: directed table, hand-written corner sequences, and random traffic
// checked every cycle against a history-based behavioural model.
module tb_snake_input_ctrl;

   localparam int N_BTN = 6;
   localparam int S     = 2;
   localparam int D     = 4;
   localparam int QD    = 4;
`ifdef SNAKE_INPUT_DEBOUNCE_EN
   localparam int LAT   = S + D;
   localparam bit DB_EN = 1'b1;
`else
   localparam int LAT   = S;
   localparam bit DB_EN = 1'b0;
`endif

   localparam int OP_PRESS = 0;
   localparam int OP_POP   = 1;
   localparam int OP_FLUSH = 2;

   logic             clk;
   logic             rst;
   logic [N_BTN-1:0] i_btn;
   logic             i_flush;
   logic             i_dir_ready;
   logic [N_BTN-1:0] o_btn_level;
   logic [N_BTN-1:0] o_btn_press;
   logic             o_dir_valid;
   logic [1:0]       o_dir;
   logic             o_queue_full;
   logic             o_overflow;

   snake_input_ctrl #(
      .N_BTN(N_BTN), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .QUEUE_DEPTH(QD), .INIT_DIR(3)
   ) dut (
      .clk(clk), .rst(rst), .i_btn(i_btn), .i_flush(i_flush), .i_dir_ready(i_dir_ready),
      .o_btn_level(o_btn_level), .o_btn_press(o_btn_press), .o_dir_valid(o_dir_valid),
      .o_dir(o_dir), .o_queue_full(o_queue_full), .o_overflow(o_overflow)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   bit chk_en   = 1'b0;
   bit ovf_seen = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // ---------------- behavioural model ----------------
   logic [N_BTN-1:0] hist [$];
   logic [N_BTN-1:0] m_level;
   logic [N_BTN-1:0] m_level_q;
   logic [1:0]       m_q [$];
   logic [1:0]       m_ref;

   function automatic logic [N_BTN-1:0] raw_at(input int k);
      if (k >= 0 && k < hist.size()) return hist[k];
      return '0;
   endfunction

   function automatic logic [2:0] m_cand(input logic [N_BTN-1:0] press);
      for (int k = 0; k < 4; k++) if (press[k]) return {1'b1, 2'(k)};
      return 3'b000;
   endfunction

   function automatic logic m_accept(input logic [2:0] c, input logic [1:0] r);
      return c[2] && (c[1:0] != r) && (c[1:0] != (r ^ 2'b01));
   endfunction

   initial begin
      m_level = '0; m_level_q = '0; m_ref = 2'd3;
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            hist.delete(); m_q.delete();
            m_level = '0; m_level_q = '0; m_ref = 2'd3;
         end else begin
            logic [2:0]       c;
            logic             acc, pop, was_full, all_diff;
            logic [N_BTN-1:0] nl, smp;
            int               k;
            c        = m_cand(m_level & ~m_level_q);
            acc      = m_accept(c, m_ref);
            pop      = i_dir_ready && (m_q.size() > 0);
            was_full = (m_q.size() == QD);
            if (i_flush) begin
               m_q.delete();
               m_ref = 2'd3;
            end else begin
               if (pop) void'(m_q.pop_front());
               if (acc && (!was_full || pop)) m_q.push_back(c[1:0]);
               if (acc) m_ref = c[1:0];
            end
            hist.push_back(i_btn);
            k  = hist.size();
            nl = m_level;
            for (int b = 0; b < N_BTN; b++) begin
               if (DB_EN) begin
                  // flips once the last D synced samples all disagree with the level
                  all_diff = 1'b1;
                  for (int j = 0; j < D; j++) begin
                     smp = raw_at(k - S - 1 - j);
                     if (smp[b] == m_level[b]) all_diff = 1'b0;
                  end
                  if (all_diff) nl[b] = ~m_level[b];
               end else begin
                  smp   = raw_at(k - S);
                  nl[b] = smp[b];
               end
            end
            m_level_q = m_level;
            m_level   = nl;
         end
      end
   end

   // ---------------- per-cycle scoreboard ----------------
   initial forever begin
      @(negedge clk);
      #2;
      if (o_overflow) ovf_seen = 1'b1;
      if (chk_en) begin
         logic [2:0]  c;
         logic        e_valid, e_ovf;
         logic [1:0]  e_dir;
         logic [16:0] exp_v, act_v;
         c       = m_cand(m_level & ~m_level_q);
         e_valid = (m_q.size() > 0);
         e_dir   = e_valid ? m_q[0] : 2'd0;
         e_ovf   = m_accept(c, m_ref) && (m_q.size() == QD) && !(i_dir_ready && e_valid) && !i_flush;
         exp_v   = {m_level, m_level & ~m_level_q, e_valid, e_dir, (m_q.size() == QD), e_ovf};
         act_v   = {o_btn_level, o_btn_press, o_dir_valid, o_dir, o_queue_full, o_overflow};
         chk("cycle", 32'(act_v), 32'(exp_v));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic press_op(input logic [3:0] mask, input logic rdy, input logic fl);
      bit seen;
      seen = 1'b0;
      @(negedge clk);
      i_btn = i_btn | {2'b00, mask};
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if ((o_btn_press[3:0] & mask) != 4'b0000) begin
            i_dir_ready = rdy;
            i_flush     = fl;
            seen        = 1'b1;
            break;
         end
      end
      chk("press_seen", 32'(seen), 32'd1);
      @(negedge clk);
      i_dir_ready = 1'b0;
      i_flush     = 1'b0;
      i_btn       = i_btn & ~{2'b00, mask};
      repeat (LAT + 3) @(negedge clk);
   endtask

   task automatic pulse_op(input bit is_flush);
      @(negedge clk);
      if (is_flush) i_flush = 1'b1;
      else          i_dir_ready = 1'b1;
      @(negedge clk);
      i_flush     = 1'b0;
      i_dir_ready = 1'b0;
      @(negedge clk);
   endtask

   typedef struct {
      int         op;
      logic [3:0] mask;
      logic       rdy;
      logic       fl;
      logic       exp_valid;
      logic [1:0] exp_head;
      logic       exp_full;
      logic       exp_ovf;
   } vec_t;

   vec_t tbl [25];

   // ---------------- main sequence ----------------
   initial begin
      rst = 1'b1; i_btn = '0; i_flush = 1'b0; i_dir_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("reset_outputs", 32'({o_btn_level, o_btn_press, o_dir_valid, o_dir, o_queue_full, o_overflow}), 32'd0);
      chk_en = 1'b1;

      // latency of a clean press on UP
      @(negedge clk);
      i_btn[0] = 1'b1;
      repeat (LAT - 1) @(negedge clk);
      chk("lat_level_early", 32'(o_btn_level[0]), 32'd0);
      @(negedge clk);
      chk("lat_level", 32'(o_btn_level[0]), 32'd1);
      chk("lat_press", 32'(o_btn_press[0]), 32'd1);
      chk("lat_valid_early", 32'(o_dir_valid), 32'd0);
      @(negedge clk);
      chk("lat_press_one", 32'(o_btn_press[0]), 32'd0);
      chk("lat_valid", 32'(o_dir_valid), 32'd1);
      chk("lat_dir", 32'(o_dir), 32'd0);

      // async reset while button 1 is mid-debounce and the queue is occupied
      i_btn[1] = 1'b1;
      repeat (3) @(negedge clk);
      chk("pre_rst_level0", 32'(o_btn_level[0]), 32'd1);
      #3 rst = 1'b1;
      #1 chk("async_rst", 32'({o_btn_level, o_btn_press, o_dir_valid, o_dir, o_queue_full, o_overflow}), 32'd0);
      i_btn = '0;
      @(negedge clk);
      rst = 1'b0;
      repeat (LAT + 3) @(negedge clk);

`ifdef SNAKE_INPUT_DEBOUNCE_EN
      begin
         bit lvl2;
         lvl2 = 1'b0;
         @(negedge clk);
         i_btn[2] = 1'b1;
         repeat (3) @(negedge clk);
         i_btn[2] = 1'b0;
         for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (o_btn_level[2]) lvl2 = 1'b1;
         end
         chk("glitch_level", 32'(lvl2), 32'd0);
         chk("glitch_queue", 32'(o_dir_valid), 32'd0);
      end
`endif

      // table: {op, mask, rdy, flush, exp_valid, exp_head, exp_full, exp_ovf}
      tbl[0]  = '{OP_PRESS, 4'b0100, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
      tbl[1]  = '{OP_PRESS, 4'b1000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
      tbl[2]  = '{OP_PRESS, 4'b0001, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0};
      tbl[3]  = '{OP_PRESS, 4'b0100, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0};
      tbl[4]  = '{OP_PRESS, 4'b0010, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0};
      tbl[5]  = '{OP_POP,   4'b0000, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0};
      tbl[6]  = '{OP_POP,   4'b0000, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0};
      tbl[7]  = '{OP_POP,   4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
      tbl[8]  = '{OP_FLUSH, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
      tbl[9]  = '{OP_PRESS, 4'b0001, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0};
      tbl[10] = '{OP_PRESS, 4'b0100, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0};
      tbl[11] = '{OP_PRESS, 4'b0010, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0};
      tbl[12] = '{OP_PRESS, 4'b1000, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0};
      tbl[13] = '{OP_PRESS, 4'b0001, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b1};
      tbl[14] = '{OP_PRESS, 4'b0100, 1'b1, 1'b0, 1'b1, 2'd2, 1'b1, 1'b0};
      tbl[15] = '{OP_FLUSH, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
      tbl[16] = '{OP_PRESS, 4'b0001, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0};
      tbl[17] = '{OP_PRESS, 4'b0100, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0};
      tbl[18] = '{OP_PRESS, 4'b0010, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0};
      tbl[19] = '{OP_PRESS, 4'b1000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
      tbl[20] = '{OP_PRESS, 4'b0100, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
      tbl[21] = '{OP_PRESS, 4'b0001, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0};
      tbl[22] = '{OP_FLUSH, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
      tbl[23] = '{OP_PRESS, 4'b0101, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0};
      tbl[24] = '{OP_POP,   4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};

      do_reset();
      for (int i = 0; i < 25; i++) begin
         ovf_seen = 1'b0;
         case (tbl[i].op)
            OP_PRESS: press_op(tbl[i].mask, tbl[i].rdy, tbl[i].fl);
            OP_POP:   pulse_op(1'b0);
            default:  pulse_op(1'b1);
         endcase
         chk($sformatf("tbl%0d_valid", i), 32'(o_dir_valid), 32'(tbl[i].exp_valid));
         chk($sformatf("tbl%0d_head", i), 32'(o_dir), 32'(tbl[i].exp_head));
         chk($sformatf("tbl%0d_full", i), 32'(o_queue_full), 32'(tbl[i].exp_full));
         chk($sformatf("tbl%0d_ovf", i), 32'(ovf_seen), 32'(tbl[i].exp_ovf));
      end

      // random traffic against the model
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         int b;
         @(negedge clk);
         if ($urandom_range(0, 7) == 0) begin
            b = $urandom_range(0, N_BTN - 1);
            i_btn[b] = ~i_btn[b];
         end
         i_dir_ready = ($urandom_range(0, 3) == 0);
         i_flush     = ($urandom_range(0, 63) == 0);
         if ($urandom_range(0, 499) == 0) begin
            #3 rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
         end
      end
      @(negedge clk);
      i_dir_ready = 1'b0;
      i_flush     = 1'b0;
      repeat (2) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
